prm_edge_scan_ctrl: RTL and testbench

// - Sequences one PRM roadmap edge-collision scan over the bank of combinational obstacle checkers.
// - Each prm_oblgc_chkN takes the 15-bit edge code A..O (A = bit 0) and returns edge_mask.
// - Steps the shared edge code through a host-given range and collects the NUM_CHK edge_mask bits.
// - Reports one result per edge on a valid/ready stream and keeps a running count of free edges.

---
 rtl/prm_pkg.sv | 15 +
 rtl/prm_res_reg.sv | 42 ++++
 rtl/prm_edge_scan_ctrl.sv | 112 +++++++++++
 tb/tb_prm_edge_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prm_pkg.sv
// Shared types and sizing for the PRM edge-scan controller.
package prm_pkg;

  localparam int PRM_ADDR_W  = 15;
  localparam int PRM_NUM_CHK = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPT,
    EMIT,
    FIN
  } prm_scan_st_t;

endpackage

// File: rtl/prm_res_reg.sv
// Output holding register for one edge result on the valid/ready stream.
// Loads a captured result, keeps it stable while stalled, and drops valid
// on the handshake. A clear request wins over both load and handshake.
module prm_res_reg
  import prm_pkg::*;
#(
  parameter int ADDR_W  = PRM_ADDR_W,
  parameter int NUM_CHK = PRM_NUM_CHK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clr,
  input  logic               ready,
  input  logic [ADDR_W-1:0]  idx_in,
  input  logic [NUM_CHK-1:0] hits_in,
  output logic               valid,
  output logic [ADDR_W-1:0]  idx,
  output logic [NUM_CHK-1:0] hits,
  output logic               blocked
);

  // Result register: clear beats load beats handshake; fields hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      idx     <= '0;
      hits    <= '0;
      blocked <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      idx     <= idx_in;
      hits    <= hits_in;
      blocked <= |hits_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/prm_edge_scan_ctrl.sv
// Sequences one PRM roadmap edge-collision scan: steps the shared edge code
// through [first, last], gives the combinational checker bank one cycle to
// settle, captures the enabled edge_mask bits and emits one result per edge
// while counting collision-free edges.
module prm_edge_scan_ctrl
  import prm_pkg::*;
#(
  parameter int ADDR_W  = PRM_ADDR_W,
  parameter int NUM_CHK = PRM_NUM_CHK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W-1:0]  scan_first,
  input  logic [ADDR_W-1:0]  scan_last,
  input  logic [NUM_CHK-1:0] obs_en,
  output logic [ADDR_W-1:0]  chk_addr,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_idx,
  output logic [NUM_CHK-1:0] out_hits,
  output logic               out_blocked,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    free_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  prm_scan_st_t       state;
  logic [ADDR_W-1:0]  last_q;
  logic [NUM_CHK-1:0] obs_en_q;
  logic               res_load;
  logic [NUM_CHK-1:0] cap_hits;

  assign cap_hits = chk_mask & obs_en_q;
  assign res_load = (state == CAPT) && !abort;
  assign busy     = (state != IDLE);

  // Scan FSM with edge-code counter and free-edge counter; abort always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chk_addr <= '0;
      last_q   <= '0;
      obs_en_q <= '0;
      free_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              last_q   <= scan_last;
              obs_en_q <= obs_en;
              free_cnt <= '0;
              if (scan_first <= scan_last) begin
                chk_addr <= scan_first;
                state    <= SETTLE;
              end else begin
                state <= FIN;
              end
            end
          end
          SETTLE: state <= CAPT;
          CAPT:   state <= EMIT;
          EMIT: begin
            if (out_valid && out_ready) begin
              if (!out_blocked) free_cnt <= free_cnt + CNT_ONE;
              // Compare before incrementing so last = all-ones never wraps.
              if (chk_addr == last_q) begin
                state <= FIN;
              end else begin
                chk_addr <= chk_addr + ADDR_ONE;
                state    <= SETTLE;
              end
            end
          end
          FIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  prm_res_reg #(
    .ADDR_W  (ADDR_W),
    .NUM_CHK (NUM_CHK)
  ) u_res_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (res_load),
    .clr     (abort),
    .ready   (out_ready),
    .idx_in  (chk_addr),
    .hits_in (cap_hits),
    .valid   (out_valid),
    .idx     (out_idx),
    .hits    (out_hits),
    .blocked (out_blocked)
  );

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// Directed bench for prm_edge_scan_ctrl with a small behavioural checker bank.
module tb_prm_edge_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [14:0] scan_first, scan_last, chk_addr, out_idx;
  logic [31:0] obs_en, chk_mask, out_hits;
  logic        out_valid, out_blocked, busy, done;
  logic [15:0] free_cnt;
  int          mode;

  int checks = 0;
  int errors = 0;

  // Results collected by run_scan
  logic [14:0] r_idx  [0:15];
  logic        r_blk  [0:15];
  logic [31:0] r_hits [0:15];
  int          r_cyc  [0:15];
  int n_res, n_done, done_cyc, first_vcyc, stall_err;
  bit timed_out, saw_zero;

  always #5 clk = ~clk;

  prm_edge_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .scan_first(scan_first), .scan_last(scan_last), .obs_en(obs_en),
    .chk_addr(chk_addr), .chk_mask(chk_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_hits(out_hits),
    .out_blocked(out_blocked), .busy(busy), .done(done), .free_cnt(free_cnt)
  );

  // Checker bank model: mask pattern chosen per test
  always_comb begin
    chk_mask = '0;
    case (mode)
      0: if (chk_addr == 15'h0012) chk_mask = 32'h0000_0008;
      1: chk_mask = '1;
      2: if (chk_addr[3:0] == 4'h3) chk_mask = 32'h0000_0020;
      default: chk_mask = '0;
    endcase
  end

  // Starts a scan (cycle 0 = start cycle) and collects results until done + 4 cycles
  task automatic run_scan(input logic [14:0] f, input logic [14:0] l, input logic [31:0] en, input int stall);
    int cyc, waitc, tail;
    logic [14:0] s_idx;
    logic [31:0] s_hits;
    logic s_blk;
    bit fin;
    n_res = 0; n_done = 0; done_cyc = -1; first_vcyc = -1; stall_err = 0;
    timed_out = 0; saw_zero = 0; waitc = 0; fin = 0; tail = 0;
    s_idx = '0; s_hits = '0; s_blk = 1'b0;
    scan_first = f; scan_last = l; obs_en = en; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; scan_first = 15'h5555; scan_last = 15'h0000; obs_en = 32'hA5A5_A5A5;
    cyc = 1;
    while (!fin && cyc < 500) begin
      if (busy && chk_addr == 15'h0000) saw_zero = 1;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid) begin
        if (first_vcyc < 0) first_vcyc = cyc;
        if (waitc == 0) begin
          s_idx = out_idx; s_hits = out_hits; s_blk = out_blocked;
        end else if (out_idx !== s_idx || out_hits !== s_hits || out_blocked !== s_blk) begin
          stall_err++;
        end
        if (waitc < stall) begin
          out_ready = 1'b0;
          waitc++;
        end else begin
          out_ready = 1'b1;
          if (n_res < 16) begin
            r_idx[n_res] = out_idx; r_blk[n_res] = out_blocked;
            r_hits[n_res] = out_hits; r_cyc[n_res] = cyc;
          end
          n_res++;
          waitc = 0;
        end
      end else begin
        out_ready = 1'b0;
      end
      if (done_cyc >= 0) begin
        tail++;
        if (tail > 4) fin = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (!fin) timed_out = 1;
  endtask

  // Waits (bounded) for out_valid; returns 1 on timeout
  task automatic wait_valid(output bit to);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    to = !out_valid;
  endtask

  task automatic test_reset;
    checks++; if (chk_addr !== 15'h0)    begin errors++; $display("FAIL rst_chk_addr got %h exp 0", chk_addr); end
    checks++; if (out_idx !== 15'h0)     begin errors++; $display("FAIL rst_out_idx got %h exp 0", out_idx); end
    checks++; if (out_hits !== 32'h0)    begin errors++; $display("FAIL rst_out_hits got %h exp 0", out_hits); end
    checks++; if (free_cnt !== 16'h0)    begin errors++; $display("FAIL rst_free_cnt got %0d exp 0", free_cnt); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_blocked !== 1'b0)  begin errors++; $display("FAIL rst_out_blocked got %b exp 0", out_blocked); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b exp 0", done); end
  endtask

  task automatic test_basic_scan;
    mode = 0;
    run_scan(15'h0010, 15'h0013, 32'hFFFF_FFFF, 0);
    checks++; if (timed_out)        begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++; if (n_res !== 4)      begin errors++; $display("FAIL basic_nres got %0d exp 4", n_res); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (r_idx[k] !== 15'h0010 + 15'(k)) begin errors++; $display("FAIL basic_idx[%0d] got %h exp %h", k, r_idx[k], 15'h0010 + 15'(k)); end
      checks++; if (r_blk[k] !== (k == 2))          begin errors++; $display("FAIL basic_blk[%0d] got %b exp %b", k, r_blk[k], (k == 2)); end
      checks++; if (r_hits[k] !== ((k == 2) ? 32'h8 : 32'h0)) begin errors++; $display("FAIL basic_hits[%0d] got %h", k, r_hits[k]); end
      checks++; if (r_cyc[k] !== 3 + 3 * k)         begin errors++; $display("FAIL basic_cyc[%0d] got %0d exp %0d", k, r_cyc[k], 3 + 3 * k); end
    end
    checks++; if (free_cnt !== 16'd3) begin errors++; $display("FAIL basic_free got %0d exp 3", free_cnt); end
    checks++; if (n_done !== 1)       begin errors++; $display("FAIL basic_ndone got %0d exp 1", n_done); end
    checks++; if (done_cyc !== 14)    begin errors++; $display("FAIL basic_done_cyc got %0d exp 14", done_cyc); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    mode = 0;
    run_scan(15'h0010, 15'h0013, 32'hFFFF_FFFF, 5);
    checks++; if (timed_out)          begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
    checks++; if (n_res !== 4)        begin errors++; $display("FAIL bp_nres got %0d exp 4", n_res); end
    checks++; if (stall_err !== 0)    begin errors++; $display("FAIL bp_stable got %0d changes exp 0", stall_err); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (r_idx[k] !== 15'h0010 + 15'(k) || r_blk[k] !== (k == 2)) begin errors++; $display("FAIL bp_res[%0d] got %h/%b", k, r_idx[k], r_blk[k]); end
    end
    checks++; if (free_cnt !== 16'd3) begin errors++; $display("FAIL bp_free got %0d exp 3", free_cnt); end
    checks++; if (n_done !== 1)       begin errors++; $display("FAIL bp_ndone got %0d exp 1", n_done); end
  endtask

  task automatic test_range_edges;
    mode = 0;
    run_scan(15'h7FFF, 15'h7FFF, 32'hFFFF_FFFF, 0);
    checks++; if (timed_out)           begin errors++; $display("FAIL top_timeout got 1 exp 0"); end
    checks++; if (n_res !== 1)         begin errors++; $display("FAIL top_nres got %0d exp 1", n_res); end
    checks++; if (r_idx[0] !== 15'h7FFF) begin errors++; $display("FAIL top_idx got %h exp 7fff", r_idx[0]); end
    checks++; if (saw_zero)            begin errors++; $display("FAIL top_wrap got chk_addr=0 exp never"); end
    checks++; if (chk_addr !== 15'h7FFF) begin errors++; $display("FAIL top_addr_hold got %h exp 7fff", chk_addr); end
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL top_ndone got %0d exp 1", n_done); end
    checks++; if (free_cnt !== 16'd1)  begin errors++; $display("FAIL top_free got %0d exp 1", free_cnt); end
    run_scan(15'h0005, 15'h0004, 32'hFFFF_FFFF, 0);
    checks++; if (timed_out)           begin errors++; $display("FAIL empty_timeout got 1 exp 0"); end
    checks++; if (n_res !== 0)         begin errors++; $display("FAIL empty_nres got %0d exp 0", n_res); end
    checks++; if (done_cyc !== 2)      begin errors++; $display("FAIL empty_done_cyc got %0d exp 2", done_cyc); end
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL empty_ndone got %0d exp 1", n_done); end
    checks++; if (free_cnt !== 16'd0)  begin errors++; $display("FAIL empty_free got %0d exp 0", free_cnt); end
  endtask

  task automatic test_enable_mask;
    mode = 1;
    run_scan(15'h0100, 15'h0104, 32'h0000_0000, 0);
    checks++; if (timed_out)          begin errors++; $display("FAIL en0_timeout got 1 exp 0"); end
    checks++; if (n_res !== 5)        begin errors++; $display("FAIL en0_nres got %0d exp 5", n_res); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (r_blk[k] !== 1'b0 || r_hits[k] !== 32'h0) begin errors++; $display("FAIL en0_res[%0d] got blk=%b hits=%h exp 0/0", k, r_blk[k], r_hits[k]); end
    end
    checks++; if (free_cnt !== 16'd5) begin errors++; $display("FAIL en0_free got %0d exp 5", free_cnt); end
    run_scan(15'h0020, 15'h0021, 32'h0000_0100, 0);
    checks++; if (n_res !== 2)        begin errors++; $display("FAIL en1_nres got %0d exp 2", n_res); end
    checks++; if (r_hits[0] !== 32'h0000_0100 || r_blk[0] !== 1'b1) begin errors++; $display("FAIL en1_res got hits=%h blk=%b exp 00000100/1", r_hits[0], r_blk[0]); end
    checks++; if (free_cnt !== 16'd0) begin errors++; $display("FAIL en1_free got %0d exp 0", free_cnt); end
  endtask

  task automatic test_abort;
    bit to;
    int dn;
    mode = 2;
    scan_first = 15'h0040; scan_last = 15'h0049; obs_en = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL abort_v1 got timeout exp valid"); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(to);
    checks++; if (to) begin errors++; $display("FAIL abort_v2 got timeout exp valid"); end
    checks++; if (free_cnt !== 16'd1) begin errors++; $display("FAIL abort_pre_free got %0d exp 1", free_cnt); end
    abort = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; out_ready = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL abort_valid got %b exp 0", out_valid); end
    checks++; if (free_cnt !== 16'd1)   begin errors++; $display("FAIL abort_free got %0d exp 1", free_cnt); end
    checks++; if (chk_addr !== 15'h0041) begin errors++; $display("FAIL abort_addr got %h exp 0041", chk_addr); end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_quiet got %0d done/busy cycles exp 0", dn); end
    abort = 1'b1; start = 1'b1; scan_first = 15'h0000; scan_last = 15'h0003;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || free_cnt !== 16'd1) begin errors++; $display("FAIL abort_vs_start got busy=%b free=%0d exp 0/1", busy, free_cnt); end
  endtask

  task automatic test_reset_mid;
    bit to;
    mode = 0;
    scan_first = 15'h0011; scan_last = 15'h0013; obs_en = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(to);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid(to);
    checks++; if (to || out_blocked !== 1'b1 || free_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre got to=%b blk=%b free=%0d exp 0/1/1", to, out_blocked, free_cnt); end
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(15'h0030, 15'h0032, 32'hFFFF_FFFF, 0);
    checks++; if (timed_out || n_res !== 3) begin errors++; $display("FAIL rmid_nres got %0d exp 3", n_res); end
    checks++; if (r_idx[0] !== 15'h0030 || r_idx[2] !== 15'h0032) begin errors++; $display("FAIL rmid_idx got %h..%h exp 0030..0032", r_idx[0], r_idx[2]); end
    checks++; if (free_cnt !== 16'd3 || n_done !== 1) begin errors++; $display("FAIL rmid_free got %0d done=%0d exp 3/1", free_cnt, n_done); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    scan_first = '0; scan_last = '0; obs_en = '0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_range_edges();
    test_enable_mask();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
